// File: rtl/uart_loopback.sv
// uart_loopback: 8N1 UART with TX FIFO, transmitter, internal serial loopback, receiver and RX FIFO.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   final_val  baud divisor limit, one 16x tick every final_val+1 clocks
//   twr_en     push strobe for the TX FIFO, twr_data is the byte pushed
//   rrd_en     pop strobe for the RX FIFO, rrd_data is its head (first-word-fall-through)
//   tx_full    TX FIFO full
//   rx_full    RX FIFO full
//   rx_empty   RX FIFO empty
module uart_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [DW-1:0] w_data,
  input  logic          rd,
  output logic [DW-1:0] r_data,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic last_wr, do_wr, do_rd;
  // Equal pointers are ambiguous; the direction of the last occupancy change resolves full vs empty.
  assign full = (wp == rp) && last_wr;
  assign empty = (wp == rp) && !last_wr;
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign r_data = mem[rp];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      last_wr <= 1'b0;
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wp] <= w_data;
        wp <= wp + 1'b1;
      end
      if (do_rd) rp <= rp + 1'b1;
      if (do_wr != do_rd) last_wr <= do_wr;
    end
  end
endmodule

module uart_loopback #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     final_val,
  input  logic            twr_en,
  input  logic [DBIT-1:0] twr_data,
  input  logic            rrd_en,
  output logic [DBIT-1:0] rrd_data,
  output logic            tx_full,
  output logic            rx_full,
  output logic            rx_empty
);
  localparam int NW = $clog2(DBIT);
  localparam logic [NW-1:0] D_LAST = NW'(DBIT - 1);
  localparam logic [3:0] SB_LAST = 4'(SB_TICK - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [10:0] cnt, lim;
  logic tick;
  // The limit is latched at each wrap so a new divisor only applies from the next period.
  assign tick = cnt == lim;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      lim <= '0;
    end else if (tick) begin
      cnt <= '0;
      lim <= final_val;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
  logic [DBIT-1:0] tx_head;
  logic tx_empty, tx_pop;
  uart_fifo #(.DW(DBIT), .AW(FIFO_AW)) tx_fifo (
    .clk(clk), .reset(reset), .wr(twr_en), .w_data(twr_data), .rd(tx_pop),
    .r_data(tx_head), .full(tx_full), .empty(tx_empty)
  );
  state_t tx_state, tx_state_n;
  logic [3:0] ts, ts_n;
  logic [NW-1:0] tn, tn_n;
  logic [DBIT-1:0] tb, tb_n;
  logic tx_reg, tx_n, rx_line;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      ts <= '0;
      tn <= '0;
      tb <= '0;
      tx_reg <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      ts <= ts_n;
      tn <= tn_n;
      tb <= tb_n;
      tx_reg <= tx_n;
    end
  end
  always_comb begin
    tx_state_n = tx_state;
    ts_n = ts;
    tn_n = tn;
    tb_n = tb;
    tx_n = tx_reg;
    tx_pop = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_n = 1'b1;
        if (!tx_empty) begin
          tx_state_n = START;
          ts_n = '0;
          tb_n = tx_head;
          tx_pop = 1'b1;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (tick) begin
          if (ts == 4'd15) begin
            tx_state_n = DATA;
            ts_n = '0;
            tn_n = '0;
          end else ts_n = ts + 1'b1;
        end
      end
      DATA: begin
        tx_n = tb[0];
        if (tick) begin
          if (ts == 4'd15) begin
            ts_n = '0;
            tb_n = tb >> 1;
            if (tn == D_LAST) tx_state_n = STOP;
            else tn_n = tn + 1'b1;
          end else ts_n = ts + 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (tick) begin
          if (ts == SB_LAST) tx_state_n = IDLE;
          else ts_n = ts + 1'b1;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_line <= 1'b1;
    else rx_line <= tx_reg;
  end
  state_t rx_state, rx_state_n;
  logic [3:0] rs, rs_n;
  logic [NW-1:0] rn, rn_n;
  logic [DBIT-1:0] rb, rb_n;
  logic rx_done;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= IDLE;
      rs <= '0;
      rn <= '0;
      rb <= '0;
    end else begin
      rx_state <= rx_state_n;
      rs <= rs_n;
      rn <= rn_n;
      rb <= rb_n;
    end
  end
  always_comb begin
    rx_state_n = rx_state;
    rs_n = rs;
    rn_n = rn;
    rb_n = rb;
    rx_done = 1'b0;
    case (rx_state)
      IDLE: begin
        if (!rx_line) begin
          rx_state_n = START;
          rs_n = '0;
        end
      end
      START: begin
        // Recheck at mid start bit so a short low glitch is not taken as a frame.
        if (tick) begin
          if (rs == 4'd7) begin
            rx_state_n = rx_line ? IDLE : DATA;
            rs_n = '0;
            rn_n = '0;
          end else rs_n = rs + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          if (rs == 4'd15) begin
            rs_n = '0;
            rb_n = {rx_line, rb[DBIT-1:1]};
            if (rn == D_LAST) rx_state_n = STOP;
            else rn_n = rn + 1'b1;
          end else rs_n = rs + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (rs == SB_LAST) begin
            rx_state_n = IDLE;
            rx_done = 1'b1;
          end else rs_n = rs + 1'b1;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end
  uart_fifo #(.DW(DBIT), .AW(FIFO_AW)) rx_fifo (
    .clk(clk), .reset(reset), .wr(rx_done), .w_data(rb), .rd(rrd_en),
    .r_data(rrd_data), .full(rx_full), .empty(rx_empty)
  );
endmodule

// File: tb/tb_uart_loopback.sv
// tb_uart_loopback: directed self-checking bench for uart_loopback.
module tb_uart_loopback;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [10:0] final_val = 11'd3;
  logic twr_en = 1'b0;
  logic [7:0] twr_data = 8'h00;
  logic rrd_en = 1'b0;
  logic [7:0] rrd_data;
  logic tx_full, rx_full, rx_empty;
  int checks = 0;
  int errors = 0;

  uart_loopback dut (
    .clk(clk), .reset(reset), .final_val(final_val), .twr_en(twr_en), .twr_data(twr_data),
    .rrd_en(rrd_en), .rrd_data(rrd_data), .tx_full(tx_full), .rx_full(rx_full), .rx_empty(rx_empty)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    logic bad;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty got %b want 1", rx_empty); end
    checks++;
    if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full got %b want 0", tx_full); end
    checks++;
    if (rx_full !== 1'b0) begin errors++; $display("FAIL reset_rx_full got %b want 0", rx_full); end
    checks++;
    if (rrd_data !== 8'h00) begin errors++; $display("FAIL reset_rrd_data got %h want 00", rrd_data); end
    checks++;
    if (dut.tx_reg !== 1'b1) begin errors++; $display("FAIL reset_line got %b want 1", dut.tx_reg); end
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_empty !== 1'b1 || rx_full !== 1'b0 || dut.tx_reg !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL idle_quiet got activity want none"); end
  endtask

  task automatic test_single;
    logic found;
    logic [7:0] got;
    found = 1'b0;
    got = 8'h00;
    @(negedge clk);
    rrd_en = 1'b1;
    twr_en = 1'b1;
    twr_data = 8'hAA;
    @(negedge clk);
    twr_en = 1'b0;
    for (int i = 0; i < 650 && !found; i++) begin
      if (!rx_empty) begin
        found = 1'b1;
        got = rrd_data;
      end else @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL single_timeout got no byte want AA within 650 clocks"); end
    checks++;
    if (got !== 8'hAA) begin errors++; $display("FAIL single_data got %h want AA", got); end
    @(negedge clk);
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL single_empty_after got %b want 1", rx_empty); end
    rrd_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] v [7];
    v = '{8'hAA, 8'h82, 8'hE2, 8'h92, 8'h8A, 8'h86, 8'h83};
    final_val = 11'd3;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      twr_en = 1'b1;
      twr_data = v[i];
    end
    @(negedge clk);
    twr_en = 1'b0;
    repeat (5200) @(negedge clk);
    checks++;
    if (rx_empty !== 1'b0) begin errors++; $display("FAIL b2b_nonempty got %b want 0", rx_empty); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (rrd_data !== v[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, rrd_data, v[i]); end
      rrd_en = 1'b1;
      @(negedge clk);
      rrd_en = 1'b0;
    end
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL b2b_drained got %b want 1", rx_empty); end
  endtask

  task automatic test_tx_full;
    logic found;
    final_val = 11'd650;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      if (i == 16) begin
        checks++;
        if (tx_full !== 1'b0) begin errors++; $display("FAIL txf_before got %b want 0", tx_full); end
      end
      if (i == 17) begin
        checks++;
        if (tx_full !== 1'b1) begin errors++; $display("FAIL txf_full got %b want 1", tx_full); end
      end
      twr_en = 1'b1;
      twr_data = 8'h10 + 8'(i);
      @(negedge clk);
    end
    twr_en = 1'b0;
    checks++;
    if (tx_full !== 1'b1) begin errors++; $display("FAIL txf_still_full got %b want 1", tx_full); end
    final_val = 11'd0;
    for (int k = 0; k < 17; k++) begin
      found = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
        if (!rx_empty) found = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL txf_timeout[%0d] got no byte want %h", k, 8'h10 + 8'(k));
      end else if (rrd_data !== 8'h10 + 8'(k)) begin
        errors++;
        $display("FAIL txf_data[%0d] got %h want %h", k, rrd_data, 8'h10 + 8'(k));
      end
      rrd_en = 1'b1;
      @(negedge clk);
      rrd_en = 1'b0;
    end
    repeat (500) @(negedge clk);
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL txf_dropped got rx_empty=%b want 1", rx_empty); end
  endtask

  task automatic test_rx_full;
    final_val = 11'd0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      twr_en = 1'b1;
      twr_data = 8'(i * 13 + 5);
    end
    @(negedge clk);
    twr_en = 1'b0;
    repeat (3200) @(negedge clk);
    checks++;
    if (rx_full !== 1'b1) begin errors++; $display("FAIL rxf_full got %b want 1", rx_full); end
    checks++;
    if (rrd_data !== 8'd5) begin errors++; $display("FAIL rxf_head got %h want 05", rrd_data); end
    rrd_en = 1'b1;
    @(negedge clk);
    rrd_en = 1'b0;
    checks++;
    if (rx_full !== 1'b0) begin errors++; $display("FAIL rxf_cleared got %b want 0", rx_full); end
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (rrd_data !== 8'(i * 13 + 5)) begin
        errors++;
        $display("FAIL rxf_data[%0d] got %h want %h", i, rrd_data, 8'(i * 13 + 5));
      end
      rrd_en = 1'b1;
      @(negedge clk);
      rrd_en = 1'b0;
    end
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL rxf_drained got %b want 1", rx_empty); end
  endtask

  task automatic test_reset_midframe;
    logic bad;
    final_val = 11'd3;
    repeat (10) @(negedge clk);
    twr_en = 1'b1;
    twr_data = 8'hE5;
    @(negedge clk);
    twr_en = 1'b0;
    repeat (350) @(negedge clk);
    checks++;
    if (dut.tx_reg !== 1'b0) begin errors++; $display("FAIL mid_bit4 got %b want 0", dut.tx_reg); end
    reset = 1'b1;
    #1;
    checks++;
    if (dut.tx_reg !== 1'b1) begin errors++; $display("FAIL mid_line got %b want 1", dut.tx_reg); end
    checks++;
    if (rx_empty !== 1'b1 || tx_full !== 1'b0 || rx_full !== 1'b0) begin
      errors++;
      $display("FAIL mid_flags got rx_empty=%b tx_full=%b rx_full=%b want 1 0 0", rx_empty, tx_full, rx_full);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rx_empty !== 1'b1 || dut.tx_reg !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL mid_no_partial got activity want none"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tx_full();
    test_rx_full();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
